// File: rtl/flex_stp_deser_pkg.sv
// Shared types and helpers for the flex serial-to-parallel deserializer family.
package flex_sr_pkg;

    typedef enum logic {
        SHIFT_LSB_FIRST = 1'b0,
        SHIFT_MSB_FIRST = 1'b1
    } shift_dir_t;

    localparam logic DEFAULT_FILL = 1'b1;

    function automatic int beats(input int num_bits, input int lanes);
        return num_bits / lanes;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flex_stp_deser_if.sv
// Serial-in / word-out bundle: the master drives bits and accepts words, the slave deserializes.
interface flex_stp_deser_if
    import flex_sr_pkg::*;
#(
    parameter int NUM_BITS = 8,
    parameter int LANES    = 1,
    parameter int CNT_W    = cnt_w(beats(NUM_BITS, LANES))
);

    logic                clear;
    logic                shift_enable;
    logic [LANES-1:0]    serial_in;
    logic [NUM_BITS-1:0] parallel_out;
    logic [NUM_BITS-1:0] word_out;
    logic                word_valid;
    logic                word_ready;
    logic                overrun;
    logic [CNT_W-1:0]    beat_count;

    modport master (
        output clear, shift_enable, serial_in, word_ready,
        input  parallel_out, word_out, word_valid, overrun, beat_count
    );

    modport slave (
        input  clear, shift_enable, serial_in, word_ready,
        output parallel_out, word_out, word_valid, overrun, beat_count
    );

endinterface

// File: rtl/flex_beat_counter.sv
// Rollover counter 0..MAX-1 with sync clear; rollover_pulse marks the enabled beat that wraps.
module flex_beat_counter #(
    parameter int MAX = 8,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         rollover_pulse
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    // Clear wins over enable, so a clearing edge never completes a word.
    assign rollover_pulse = enable && !clear && (count == LAST);

endmodule

// File: rtl/flex_stp_deser.sv
// LANES-wide serial-to-parallel deserializer with beat framing, word holding register,
// valid/ready hand-off and sticky overrun.
module flex_stp_deser
    import flex_sr_pkg::*;
#(
    parameter int   NUM_BITS   = 8,
    parameter int   LANES      = 1,
    parameter bit   SHIFT_MSB  = 1'b1,
    parameter logic RESET_FILL = DEFAULT_FILL
) (
    input logic              clk,
    input logic              rst,
    flex_stp_deser_if.slave  bus
);

    localparam int         BEATS = beats(NUM_BITS, LANES);
    localparam int         CNT_W = cnt_w(BEATS);
    localparam shift_dir_t DIR   = shift_dir_t'(SHIFT_MSB);

    logic [NUM_BITS-1:0] q;
    logic [NUM_BITS-1:0] q_next;
    logic [NUM_BITS-1:0] word_q;
    logic                valid_q;
    logic                ovr_q;
    logic [CNT_W-1:0]    cnt;
    logic                done;

    generate
        if (DIR == SHIFT_MSB_FIRST) begin : g_msb
            assign q_next = {q[NUM_BITS-LANES-1:0], bus.serial_in};
        end else begin : g_lsb
            assign q_next = {bus.serial_in, q[NUM_BITS-1:LANES]};
        end
    endgenerate

    flex_beat_counter #(
        .MAX (BEATS),
        .W   (CNT_W)
    ) u_beat_counter (
        .clk            (clk),
        .rst            (rst),
        .clear          (bus.clear),
        .enable         (bus.shift_enable),
        .count          (cnt),
        .rollover_pulse (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= {NUM_BITS{RESET_FILL}};
        else if (bus.clear)
            q <= {NUM_BITS{RESET_FILL}};
        else if (bus.shift_enable)
            q <= q_next;
    end

    // Holding register captures the post-shift value on the completing edge;
    // clear keeps the last word but drops valid and overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (bus.clear) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (done) begin
            word_q  <= q_next;
            valid_q <= 1'b1;
            if (valid_q && !bus.word_ready)
                ovr_q <= 1'b1;
        end else if (valid_q && bus.word_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.parallel_out = q;
    assign bus.word_out     = word_q;
    assign bus.word_valid   = valid_q;
    assign bus.overrun      = ovr_q;
    assign bus.beat_count   = cnt;

endmodule

// File: tb/tb_flex_stp_deser.sv
// Scoreboard bench: three deserializers (8b x1 MSB-first, 8b x1 LSB-first, 8b x2 MSB-first)
// share control inputs; directed scenarios then randomized traffic against a beat-list model.
module tb_flex_stp_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear, en, rdy, sa;
    logic [1:0] sc;

    always #5 clk = ~clk;

    flex_stp_deser_if #(.NUM_BITS(8), .LANES(1)) ifa ();
    flex_stp_deser_if #(.NUM_BITS(8), .LANES(1)) ifb ();
    flex_stp_deser_if #(.NUM_BITS(8), .LANES(2)) ifc ();

    assign ifa.clear = clear;  assign ifa.shift_enable = en;  assign ifa.serial_in = sa;  assign ifa.word_ready = rdy;
    assign ifb.clear = clear;  assign ifb.shift_enable = en;  assign ifb.serial_in = sa;  assign ifb.word_ready = rdy;
    assign ifc.clear = clear;  assign ifc.shift_enable = en;  assign ifc.serial_in = sc;  assign ifc.word_ready = rdy;

    flex_stp_deser #(.NUM_BITS(8), .LANES(1), .SHIFT_MSB(1'b1), .RESET_FILL(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    flex_stp_deser #(.NUM_BITS(8), .LANES(1), .SHIFT_MSB(1'b0), .RESET_FILL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    flex_stp_deser #(.NUM_BITS(8), .LANES(2), .SHIFT_MSB(1'b1), .RESET_FILL(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int n_cmp = 0;
    int n_err = 0;

    // Model state: streams since last reset/clear (ha/hc), beats of the current frame (fa/fc),
    // pending words ({A,B} for the single-lane pair, C alone), and valid/overrun flags.
    logic [1:0]  ha[$], fa[$], hc[$], fc[$];
    logic [15:0] qa[$];
    logic [7:0]  qc[$];
    bit          m_va, m_oa, m_vc, m_oc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ha.delete(); fa.delete(); hc.delete(); fc.delete();
        qa.delete(); qc.delete();
        m_va = 0; m_oa = 0; m_vc = 0; m_oc = 0;
    endtask

    // Live register: all-ones fill followed by every beat shifted in since reset/clear.
    function automatic logic [7:0] live_val(input logic [1:0] h[$], input int L, input bit msb);
        logic [7:0] v;
        v = 8'hFF;
        foreach (h[i])
            if (msb) v = 8'((32'(v) << L) | 32'(h[i]));
            else     v = 8'((32'(v) >> L) | (32'(h[i]) << (8 - L)));
        return v;
    endfunction

    // Word from one frame: MSB-first puts the first beat on top, LSB-first puts beat i at bit L*i.
    function automatic logic [7:0] frame_word(input logic [1:0] h[$], input int L, input bit msb);
        logic [7:0] w;
        w = 8'h00;
        foreach (h[i])
            if (msb) w = 8'((32'(w) << L) | 32'(h[i]));
            else     w = 8'(32'(w) | (32'(h[i]) << (L * i)));
        return w;
    endfunction

    // Reference model: advances on each rising edge from the inputs the driver presented.
    initial forever begin
        bit xa, xc;
        @(posedge clk);
        if (!rst) begin
            if (clear) begin
                model_reset();
            end else begin
                xa = m_va && rdy;
                xc = m_vc && rdy;
                if (en) begin
                    ha.push_back({1'b0, sa}); if (ha.size() > 8) void'(ha.pop_front());
                    fa.push_back({1'b0, sa});
                    hc.push_back(sc);         if (hc.size() > 4) void'(hc.pop_front());
                    fc.push_back(sc);
                end
                if (en && fa.size() == 8) begin
                    if (m_va && !xa) begin void'(qa.pop_back()); m_oa = 1; end
                    qa.push_back({frame_word(fa, 1, 1), frame_word(fa, 1, 0)});
                    fa.delete();
                    m_va = 1;
                end else if (xa) m_va = 0;
                if (en && fc.size() == 4) begin
                    if (m_vc && !xc) begin void'(qc.pop_back()); m_oc = 1; end
                    qc.push_back(frame_word(fc, 2, 1));
                    fc.delete();
                    m_vc = 1;
                end else if (xc) m_vc = 0;
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard whenever a word is accepted.
    initial forever begin
        logic [15:0] ea;
        logic [7:0]  ec;
        @(negedge clk); #1;
        chk("A.valid", ifa.word_valid, m_va);  chk("A.ovr", ifa.overrun, m_oa);
        chk("B.valid", ifb.word_valid, m_va);  chk("B.ovr", ifb.overrun, m_oa);
        chk("C.valid", ifc.word_valid, m_vc);  chk("C.ovr", ifc.overrun, m_oc);
        chk("A.cnt", ifa.beat_count, fa.size());
        chk("B.cnt", ifb.beat_count, fa.size());
        chk("C.cnt", ifc.beat_count, fc.size());
        chk("A.po", ifa.parallel_out, live_val(ha, 1, 1));
        chk("B.po", ifb.parallel_out, live_val(ha, 1, 0));
        chk("C.po", ifc.parallel_out, live_val(hc, 2, 1));
        if (ifa.word_valid && rdy) begin
            if (qa.size() == 0) chk("A.sb_underflow", qa.size(), 1);
            else begin
                ea = qa.pop_front();
                chk("A.word", ifa.word_out, ea[15:8]);
                chk("B.word", ifb.word_out, ea[7:0]);
            end
        end
        if (ifc.word_valid && rdy) begin
            if (qc.size() == 0) chk("C.sb_underflow", qc.size(), 1);
            else begin
                ec = qc.pop_front();
                chk("C.word", ifc.word_out, ec);
            end
        end
    end

    task automatic cyc(input bit e, input logic a, input logic [1:0] c, input bit r);
        @(negedge clk);
        clear = 1'b0; en = e; sa = a; sc = c; rdy = r;
    endtask

    task automatic idle(input bit r);
        cyc(1'b0, 1'b0, 2'b00, r);
    endtask

    task automatic send_a(input logic [7:0] w, input bit r);
        for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], 2'($urandom), r);
    endtask

    task automatic clr();
        @(negedge clk);
        clear = 1'b1; en = 1'b1; sa = 1'($urandom); sc = 2'($urandom); rdy = 1'($urandom);
    endtask

    task automatic async_rst();
        @(negedge clk); #3;
        rst = 1'b1; en = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; clear = 1'b0; en = 1'b0; rdy = 1'b0; sa = 1'b0; sc = 2'b00;
        repeat (2) @(negedge clk);
        #2;
        chk("rst.po", ifa.parallel_out, 8'hFF);
        chk("rst.word", ifa.word_out, 8'h00);
        chk("rst.valid", ifa.word_valid, 1'b0);
        chk("rst.ovr", ifa.overrun, 1'b0);
        chk("rst.cnt", ifa.beat_count, 3'd0);
        chk("rst.c_po", ifc.parallel_out, 8'hFF);
        rst = 1'b0;

        // 1: MSB-first and LSB-first framing of the same bit sequence, ready held high
        send_a(8'hB2, 1'b1);
        idle(1'b1); #2;
        chk("t1.a_word", ifa.word_out, 8'hB2);
        chk("t1.b_word", ifb.word_out, 8'h4D);
        chk("t1.a_valid", ifa.word_valid, 1'b1);
        chk("t1.a_cnt", ifa.beat_count, 3'd0);
        idle(1'b1); #2;
        chk("t1.a_valid_drop", ifa.word_valid, 1'b0);

        // 2: two-lane beats
        clr();
        cyc(1'b1, 1'b0, 2'b10, 1'b1);
        cyc(1'b1, 1'b1, 2'b11, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b1);
        cyc(1'b1, 1'b1, 2'b01, 1'b1);
        idle(1'b0); #2;
        chk("t2.c_word", ifc.word_out, 8'hB1);
        chk("t2.c_valid", ifc.word_valid, 1'b1);

        // 3: overrun, drain, then clear
        clr();
        send_a(8'hB2, 1'b0);
        send_a(8'h0F, 1'b0);
        idle(1'b0); #2;
        chk("t3.word", ifa.word_out, 8'h0F);
        chk("t3.valid", ifa.word_valid, 1'b1);
        chk("t3.ovr", ifa.overrun, 1'b1);
        idle(1'b1);
        idle(1'b0); #2;
        chk("t3.valid_drained", ifa.word_valid, 1'b0);
        chk("t3.ovr_sticky", ifa.overrun, 1'b1);
        clr();
        idle(1'b0); #2;
        chk("t3.ovr_cleared", ifa.overrun, 1'b0);
        chk("t3.word_held", ifa.word_out, 8'h0F);

        // 4: second word completes on the edge that accepts the first
        clr();
        send_a(8'h5A, 1'b0);
        w = 8'hC3;
        for (int i = 7; i >= 1; i--) cyc(1'b1, w[i], 2'($urandom), 1'b0);
        cyc(1'b1, w[0], 2'($urandom), 1'b1);
        idle(1'b0); #2;
        chk("t4.valid", ifa.word_valid, 1'b1);
        chk("t4.word", ifa.word_out, 8'hC3);
        chk("t4.ovr", ifa.overrun, 1'b0);
        idle(1'b1);

        // 5: async reset mid-word with a word pending
        clr();
        send_a(8'h77, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 2'($urandom), 1'b0);
        async_rst();
        chk("t5.po", ifa.parallel_out, 8'hFF);
        chk("t5.cnt", ifa.beat_count, 3'd0);
        chk("t5.valid", ifa.word_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_a(8'h3C, 1'b1);
        idle(1'b1); #2;
        chk("t5.word", ifa.word_out, 8'h3C);

        // 6: gapped beats, then clear beating shift_enable
        clr();
        w = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, w[i], 2'($urandom), 1'b1);
            idle(1'b1);
            idle(1'b1);
        end
        #2;
        chk("t6.gap_word", ifa.word_out, 8'hB2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'($urandom), 1'b1);
        clr();
        idle(1'b1); #2;
        chk("t6.clr_po", ifa.parallel_out, 8'hFF);
        chk("t6.clr_cnt", ifa.beat_count, 3'd0);

        // Randomized traffic with occasional clear and async reset
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 3) clr();
            else if (r == 3) begin
                async_rst();
                @(negedge clk);
                rst = 1'b0;
            end else
                cyc(($urandom % 4) != 0, 1'($urandom), 2'($urandom), ($urandom % 3) != 0);
        end
        repeat (4) idle(1'b1);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
